// File: rtl/pwm_ctrl_pkg.sv
// Shared definitions for the PWM ramp controller slice.
//   DEF_DUTY_W   : default width of the PWM compare (duty) value
//   DEF_RATE_W   : default width of the step-rate field, in PWM periods
//   ramp_state_t : controller state encoding (IDLE, RAMP, FINISH)
package pwm_ctrl_pkg;

  localparam int DEF_DUTY_W = 8;
  localparam int DEF_RATE_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RAMP   = 2'd1,
    FINISH = 2'd2
  } ramp_state_t;

endpackage : pwm_ctrl_pkg

// File: rtl/pwm_step_timer.sv
// Counts PWM period ticks and flags when a duty step is due.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   tick  : one-cycle period-boundary pulse from the PWM counter
//   clear : holds the counter at zero (used whenever no ramp is running)
//   rate  : periods per step; 0 means step on the very first tick
//   step  : high in the cycle of the tick on which a step is due
module pwm_step_timer
  import pwm_ctrl_pkg::*;
#(
  parameter int RATE_W = DEF_RATE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick,
  input  logic              clear,
  input  logic [RATE_W-1:0] rate,
  output logic              step
);

  logic [RATE_W-1:0] r_count;
  logic [RATE_W:0]   w_countNext;

  // One extra bit so rate = all-ones still compares correctly.
  assign w_countNext = {1'b0, r_count} + (RATE_W+1)'(1);

  assign step = tick & ~clear & ((rate == '0) | (w_countNext == {1'b0, rate}));

  // Counter advances per tick and restarts each time a step fires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (tick) begin
      if (step) begin
        r_count <= '0;
      end else begin
        r_count <= w_countNext[RATE_W-1:0];
      end
    end
  end

endmodule : pwm_step_timer

// File: rtl/pwm_ramp_ctrl.sv
// Ramps a PWM duty value toward a commanded target, one LSB per
// configurable number of PWM periods, updating only at period boundaries.
//   clk         : clock, rising edge
//   rst_n       : asynchronous active-low reset
//   period_tick : one-cycle pulse at PWM counter wrap
//   cmd_valid   : ramp command offered
//   cmd_ready   : command can be accepted (IDLE only)
//   cmd_target  : final duty value
//   cmd_rate    : PWM periods per 1-LSB step; 0 = jump on first tick
//   abort       : cancel the ramp in progress, keeping current duty
//   duty        : registered compare value for the PWM
//   busy        : ramp in progress (RAMP or FINISH)
//   done        : one-cycle pulse when a ramp completes or is aborted
module pwm_ramp_ctrl
  import pwm_ctrl_pkg::*;
#(
  parameter int DUTY_W = DEF_DUTY_W,
  parameter int RATE_W = DEF_RATE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              period_tick,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DUTY_W-1:0] cmd_target,
  input  logic [RATE_W-1:0] cmd_rate,
  input  logic              abort,
  output logic [DUTY_W-1:0] duty,
  output logic              busy,
  output logic              done
);

  ramp_state_t       r_state;
  logic [DUTY_W-1:0] r_duty;
  logic [DUTY_W-1:0] r_target;
  logic [RATE_W-1:0] r_rate;
  logic              r_busy;
  logic              r_done;
  logic              r_ready;

  logic              w_clear;
  logic              w_step;
  logic [DUTY_W-1:0] w_dutyNext;

  // Counter only runs in RAMP, so a tick in the acceptance cycle is not counted.
  assign w_clear = (r_state != RAMP);

  pwm_step_timer #(
    .RATE_W (RATE_W)
  ) u_step_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (period_tick),
    .clear (w_clear),
    .rate  (r_rate),
    .step  (w_step)
  );

  // Next duty moves one LSB toward the target, so it can never overshoot
  // the target nor wrap past either end of the range.
  always_comb begin
    w_dutyNext = r_duty;
    if (r_rate == '0) begin
      w_dutyNext = r_target;
    end else if (r_target > r_duty) begin
      w_dutyNext = r_duty + DUTY_W'(1);
    end else if (r_target < r_duty) begin
      w_dutyNext = r_duty - DUTY_W'(1);
    end
  end

  // Controller FSM with registered outputs; done is high exactly while in FINISH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_duty   <= '0;
      r_target <= '0;
      r_rate   <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_ready  <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (cmd_valid) begin
            r_target <= cmd_target;
            r_rate   <= cmd_rate;
            r_ready  <= 1'b0;
            r_busy   <= 1'b1;
            if (cmd_target == r_duty) begin
              r_state <= FINISH;
              r_done  <= 1'b1;
            end else begin
              r_state <= RAMP;
            end
          end
        end
        RAMP: begin
          // Abort wins over a coincident step.
          if (abort) begin
            r_state <= FINISH;
            r_done  <= 1'b1;
          end else if (w_step) begin
            r_duty <= w_dutyNext;
            if (w_dutyNext == r_target) begin
              r_state <= FINISH;
              r_done  <= 1'b1;
            end
          end
        end
        FINISH: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign duty      = r_duty;
  assign busy      = r_busy;
  assign done      = r_done;
  assign cmd_ready = r_ready;

endmodule : pwm_ramp_ctrl
